// File: rtl/instr_adder_meas_ctrl.sv
// ---------------------------------------------------------------------------
// instr_adder_meas_ctrl
//
// Measurement sequencer for the instrumented Brent-Kung adder. A single
// measurement runs IDLE -> LOAD -> SETTLE -> RUN -> DRAIN -> DONE:
//   - The operands and a one-hot bit mask are captured and presented to the adder.
//   - After a settle period the ring path is enabled for window_len cycles.
//   - Rising edges of chain_out are counted during RUN and DRAIN, so firmware
//     can derive the carry-chain delay from the count.
//
// Optional feature macro: INSTR_ADDER_MEAS_TIMEOUT_EN
//   When defined, an 8-bit stall counter aborts RUN into DRAIN after 255
//   consecutive RUN cycles with no counted edge. It also raises the sticky
//   'timeout' output, which is cleared on accept.
//
// Ports:
//   wb_clk_i            system clock (only clock)
//   wb_rst_i            synchronous active-high reset
//   start               level request, accepted only in IDLE
//   mode                0 = ring mode, 1 = external-drive mode
//   bit_sel             adder bit index to exercise
//   window_len          RUN length in cycles (0 treated as 1)
//   a_operand/b_operand operands captured on accept
//   chain_out           adder carry-chain output, asynchronous
//   a_input/b_input     registered operands to the adder
//   a_input_ring_bit_b  one-hot ring-path mask (mode 0)
//   a_input_ext_bit_b   one-hot external-drive mask (mode 1)
//   ring_en             high only in RUN
//   busy                high from LOAD through DRAIN
//   done                one-cycle pulse in DONE
//   count               edge count, held until the next accept
//   overflow            sticky saturation flag, cleared on accept
//   timeout             (optional) sticky stall-abort flag
// ---------------------------------------------------------------------------
module instr_adder_meas_ctrl #(
  parameter int COUNT_W    = 32,
  parameter int WINDOW_W   = 16,
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_CYC  = 3
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic                mode,
  input  logic [4:0]          bit_sel,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic [31:0]         a_operand,
  input  logic [31:0]         b_operand,
  input  logic                chain_out,
`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
  output logic                timeout,
`endif
  output logic [31:0]         a_input,
  output logic [31:0]         b_input,
  output logic [31:0]         a_input_ring_bit_b,
  output logic [31:0]         a_input_ext_bit_b,
  output logic                ring_en,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  count,
  output logic                overflow
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [WINDOW_W-1:0] SETTLE_LOAD = WINDOW_W'(SETTLE_CYC - 1);
  localparam logic [WINDOW_W-1:0] DRAIN_LOAD  = WINDOW_W'(DRAIN_CYC - 1);

  logic [2:0]          r_state;
  logic [WINDOW_W-1:0] r_timer;
  logic [WINDOW_W-1:0] r_winLen;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_hist;
`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
  logic [7:0]          r_stall;
`endif

  logic                w_rise;
  logic                w_countEn;
  logic [31:0]         w_mask;

  // A rising edge is a synchronized 1 whose previous sample was 0. Edges
  // are still accepted in DRAIN so the synchronizer pipeline can empty.
  assign w_rise    = r_sync2 & ~r_hist;
  assign w_countEn = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_mask    = 32'd1 << bit_sel;

  // busy drops in DONE so it falls in the same cycle that done pulses.
  assign ring_en = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign busy    = (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state            <= S_IDLE;
      r_timer            <= '0;
      r_winLen           <= '0;
      r_sync1            <= 1'b0;
      r_sync2            <= 1'b0;
      r_hist             <= 1'b0;
      a_input            <= '0;
      b_input            <= '0;
      a_input_ring_bit_b <= '0;
      a_input_ext_bit_b  <= '0;
      count              <= '0;
      overflow           <= 1'b0;
`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
      r_stall            <= '0;
      timeout            <= 1'b0;
`endif
    end else begin
      // The history flop follows the synchronizer in every state, so an
      // edge already seen in SETTLE is not counted again on RUN entry.
      r_sync1 <= chain_out;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;

      case (r_state)
        S_IDLE: begin
          // The operands and masks are captured straight into the output
          // registers, so they are already valid during LOAD.
          if (start) begin
            a_input            <= a_operand;
            b_input            <= b_operand;
            a_input_ring_bit_b <= mode ? 32'd0 : w_mask;
            a_input_ext_bit_b  <= mode ? w_mask : 32'd0;
            r_winLen           <= (window_len == '0) ? WINDOW_W'(1) : window_len;
            count              <= '0;
            overflow           <= 1'b0;
`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
            timeout            <= 1'b0;
`endif
            r_state            <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_timer <= SETTLE_LOAD;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_timer == '0) begin
            r_timer <= r_winLen - 1'b1;
`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
            r_stall <= '0;
`endif
            r_state <= S_RUN;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_RUN: begin
`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
          // A count of 254 with no edge in this cycle completes 255 idle
          // RUN cycles, so the ring is treated as dead.
          if (w_rise) begin
            r_stall <= '0;
          end else begin
            r_stall <= r_stall + 1'b1;
          end
`endif
          if (r_timer == '0) begin
            r_timer <= DRAIN_LOAD;
            r_state <= S_DRAIN;
`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
          end else if (!w_rise && (r_stall == 8'd254)) begin
            r_timer <= DRAIN_LOAD;
            timeout <= 1'b1;
            r_state <= S_DRAIN;
`endif
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_timer == '0) begin
            r_state <= S_DONE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Counting is disjoint from IDLE, where the accept clears the count.
      // An edge that arrives at all-ones leaves the count saturated and
      // marks the result as overflowed.
      if (w_countEn && w_rise) begin
        if (&count) begin
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_adder_meas_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_adder_meas_ctrl
//
// Directed bench for instr_adder_meas_ctrl. There are two instances:
//   - dut  uses the default 32-bit counter.
//   - dut4 uses a 4-bit counter, to show saturation.
// Both instances share every input, and one chain_out stub drives both.
// The stub toggles chain_out at each falling edge while ring_en is high.
// Optional feature macro: INSTR_ADDER_MEAS_TIMEOUT_EN
// ---------------------------------------------------------------------------
module tb_instr_adder_meas_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start;
  logic        mode;
  logic [4:0]  bit_sel;
  logic [15:0] window_len;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        chain_out = 1'b0;

  logic [31:0] a_input, b_input, a_input_ring_bit_b, a_input_ext_bit_b;
  logic        ring_en, busy, done, overflow;
  logic [31:0] count;

  logic [31:0] a4, b4, rm4, em4;
  logic        re4, busy4, done4, ovf4;
  logic [3:0]  count4;

`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
  logic        timeout, timeout4;
  localparam int EXT_WIN = 1000;
  localparam int EXT_RUN = 255;
`else
  localparam int EXT_WIN = 20;
  localparam int EXT_RUN = 20;
`endif

  int total = 0;
  int bad   = 0;
  int ringHighCnt = 0;
  int doneCnt = 0;
  logic stubEn = 1'b0;

  instr_adder_meas_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .mode(mode),
    .bit_sel(bit_sel), .window_len(window_len), .a_operand(a_operand),
    .b_operand(b_operand), .chain_out(chain_out),
`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
    .timeout(timeout),
`endif
    .a_input(a_input), .b_input(b_input),
    .a_input_ring_bit_b(a_input_ring_bit_b), .a_input_ext_bit_b(a_input_ext_bit_b),
    .ring_en(ring_en), .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  instr_adder_meas_ctrl #(.COUNT_W(4)) dut4 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .mode(mode),
    .bit_sel(bit_sel), .window_len(window_len), .a_operand(a_operand),
    .b_operand(b_operand), .chain_out(chain_out),
`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
    .timeout(timeout4),
`endif
    .a_input(a4), .b_input(b4),
    .a_input_ring_bit_b(rm4), .a_input_ext_bit_b(em4),
    .ring_en(re4), .busy(busy4), .done(done4), .count(count4), .overflow(ovf4)
  );

  // 10 ns clock
  always #5 wb_clk_i = ~wb_clk_i;

  // This block is the ring stub and also counts ring_en-high and done cycles.
  always @(negedge wb_clk_i) begin
    if (!stubEn) chain_out = 1'b0;
    else if (ring_en) chain_out = ~chain_out;
    if (ring_en) ringHighCnt++;
    if (done) doneCnt++;
  end

  // Presents start for one cycle (c0). The task returns at the falling edge
  // of c1, when the DUT is in LOAD.
  task automatic startMeas(input logic m, input logic [4:0] bs, input logic [15:0] wl,
                           input logic [31:0] a, input logic [31:0] b);
    @(negedge wb_clk_i);
    mode = m; bit_sel = bs; window_len = wl; a_operand = a; b_operand = b;
    start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
  endtask

  // Returns how many falling edges pass before done is seen, or -1 if the
  // budget runs out first.
  task automatic waitDone(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget && cyc < 0; i++) begin
      @(negedge wb_clk_i);
      if (done === 1'b1) cyc = i;
    end
  endtask

  // Drives chain_out low for a few cycles so every test starts from 0.
  task automatic quietStub();
    stubEn = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    stubEn = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge wb_clk_i);
    total++; if (busy !== 1'b0 || ring_en !== 1'b0 || done !== 1'b0) begin bad++;
      $display("[TB] FAIL reset_ctrl busy=%b ring_en=%b done=%b want 0", busy, ring_en, done); end
    total++; if (count !== 32'd0 || overflow !== 1'b0) begin bad++;
      $display("[TB] FAIL reset_count count=%0d ovf=%b want 0", count, overflow); end
    wb_rst_i = 1'b0;
    quietStub();
    // Reset is asserted in the middle of RUN, after some edges are counted.
    startMeas(1'b0, 5'd7, 16'd50, 32'hA5A5A5A5, 32'h5A5A5A5A);
    n = 0;
    while (ring_en !== 1'b1 && n < 20) begin @(negedge wb_clk_i); n++; end
    total++; if (ring_en !== 1'b1) begin bad++;
      $display("[TB] FAIL reset_reach_run ring_en=%b want 1", ring_en); end
    repeat (12) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    total++; if (busy !== 1'b0 || ring_en !== 1'b0) begin bad++;
      $display("[TB] FAIL reset_mid_run busy=%b ring_en=%b want 0", busy, ring_en); end
    total++; if (count !== 32'd0 || a_input !== 32'd0 || b_input !== 32'd0) begin bad++;
      $display("[TB] FAIL reset_mid_data count=%0d a=%h b=%h want 0", count, a_input, b_input); end
    total++; if (a_input_ring_bit_b !== 32'd0 || a_input_ext_bit_b !== 32'd0) begin bad++;
      $display("[TB] FAIL reset_mid_masks ring=%h ext=%h want 0", a_input_ring_bit_b, a_input_ext_bit_b); end
  endtask

  task automatic test_ring();
    int r0, d0, cyc;
    quietStub();
    r0 = ringHighCnt; d0 = doneCnt;
    startMeas(1'b0, 5'd26, 16'd100, 32'd0, 32'd0);
    total++; if (a_input_ring_bit_b !== 32'h04000000 || a_input_ext_bit_b !== 32'd0) begin bad++;
      $display("[TB] FAIL ring_masks ring=%h ext=%h want 04000000/00000000", a_input_ring_bit_b, a_input_ext_bit_b); end
    total++; if (busy !== 1'b1) begin bad++;
      $display("[TB] FAIL ring_busy busy=%b want 1", busy); end
    waitDone(300, cyc);
    // From LOAD: 1 LOAD + 4 SETTLE + 100 RUN + 3 DRAIN, then DONE.
    total++; if (cyc != 108) begin bad++;
      $display("[TB] FAIL ring_done_latency got=%0d want 108", cyc); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("[TB] FAIL ring_busy_at_done busy=%b want 0", busy); end
    total++; if (count !== 32'd50 || overflow !== 1'b0) begin bad++;
      $display("[TB] FAIL ring_count count=%0d ovf=%b want 50/0", count, overflow); end
    repeat (3) @(negedge wb_clk_i);
    total++; if (ringHighCnt - r0 != 100) begin bad++;
      $display("[TB] FAIL ring_en_cycles got=%0d want 100", ringHighCnt - r0); end
    total++; if (doneCnt - d0 != 1) begin bad++;
      $display("[TB] FAIL ring_done_pulses got=%0d want 1", doneCnt - d0); end
    total++; if (count !== 32'd50) begin bad++;
      $display("[TB] FAIL ring_count_held count=%0d want 50", count); end
  endtask

  task automatic test_window_zero();
    int r0, cyc;
    quietStub();
    r0 = ringHighCnt;
    startMeas(1'b0, 5'd26, 16'd0, 32'd0, 32'd0);
    waitDone(50, cyc);
    // Counting from the start cycle: 2 (IDLE+LOAD) + 4 + 1 + 3 = 10.
    total++; if (cyc + 1 != 10) begin bad++;
      $display("[TB] FAIL wz_done_latency got=%0d want 10", cyc + 1); end
    total++; if (count > 32'd1) begin bad++;
      $display("[TB] FAIL wz_count count=%0d want <=1", count); end
    repeat (2) @(negedge wb_clk_i);
    total++; if (ringHighCnt - r0 != 1) begin bad++;
      $display("[TB] FAIL wz_ring_cycles got=%0d want 1", ringHighCnt - r0); end
  endtask

  task automatic test_busy_ignore();
    int d0, cyc;
    quietStub();
    d0 = doneCnt;
    startMeas(1'b0, 5'd26, 16'd5, 32'd0, 32'd0);
    @(negedge wb_clk_i);
    bit_sel = 5'd3; start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    total++; if (a_input_ring_bit_b !== 32'h04000000) begin bad++;
      $display("[TB] FAIL bi_mask_settle ring=%h want 04000000", a_input_ring_bit_b); end
    waitDone(50, cyc);
    total++; if (cyc < 0) begin bad++;
      $display("[TB] FAIL bi_done_seen got=timeout want done"); end
    repeat (15) @(negedge wb_clk_i);
    total++; if (doneCnt - d0 != 1 || busy !== 1'b0) begin bad++;
      $display("[TB] FAIL bi_single_done got=%0d busy=%b want 1/0", doneCnt - d0, busy); end
    total++; if (a_input_ring_bit_b !== 32'h04000000) begin bad++;
      $display("[TB] FAIL bi_mask_after ring=%h want 04000000", a_input_ring_bit_b); end
  endtask

  task automatic test_saturation();
    int cyc;
    quietStub();
    startMeas(1'b0, 5'd1, 16'd64, 32'd0, 32'd0);
    waitDone(200, cyc);
    total++; if (count !== 32'd32 || overflow !== 1'b0) begin bad++;
      $display("[TB] FAIL sat_wide count=%0d ovf=%b want 32/0", count, overflow); end
    total++; if (count4 !== 4'hF || ovf4 !== 1'b1) begin bad++;
      $display("[TB] FAIL sat_narrow count=%h ovf=%b want F/1", count4, ovf4); end
    repeat (2) @(negedge wb_clk_i);
    startMeas(1'b0, 5'd1, 16'd1, 32'd0, 32'd0);
    total++; if (count4 !== 4'h0 || ovf4 !== 1'b0 || count !== 32'd0) begin bad++;
      $display("[TB] FAIL sat_clear count4=%h ovf4=%b count=%0d want 0", count4, ovf4, count); end
    waitDone(50, cyc);
    total++; if (cyc < 0) begin bad++;
      $display("[TB] FAIL sat_second_done got=timeout want done"); end
  endtask

  task automatic test_ext_mode();
    int r0, cyc;
    stubEn = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    r0 = ringHighCnt;
    startMeas(1'b1, 5'd0, 16'(EXT_WIN), 32'hDEADBEEF, 32'h12345678);
    total++; if (a_input_ext_bit_b !== 32'h00000001 || a_input_ring_bit_b !== 32'd0) begin bad++;
      $display("[TB] FAIL ext_masks ext=%h ring=%h want 00000001/00000000", a_input_ext_bit_b, a_input_ring_bit_b); end
    total++; if (a_input !== 32'hDEADBEEF || b_input !== 32'h12345678) begin bad++;
      $display("[TB] FAIL ext_operands a=%h b=%h want DEADBEEF/12345678", a_input, b_input); end
    waitDone(2000, cyc);
    total++; if (cyc < 0 || count !== 32'd0) begin bad++;
      $display("[TB] FAIL ext_count cyc=%0d count=%0d want done/0", cyc, count); end
    repeat (2) @(negedge wb_clk_i);
    total++; if (ringHighCnt - r0 != EXT_RUN) begin bad++;
      $display("[TB] FAIL ext_run_cycles got=%0d want %0d", ringHighCnt - r0, EXT_RUN); end
`ifdef INSTR_ADDER_MEAS_TIMEOUT_EN
    total++; if (timeout !== 1'b1) begin bad++;
      $display("[TB] FAIL ext_timeout got=%b want 1", timeout); end
`endif
    stubEn = 1'b1;
  endtask

  initial begin
    wb_rst_i = 1'b1; start = 1'b0; mode = 1'b0; bit_sel = 5'd0;
    window_len = 16'd0; a_operand = 32'd0; b_operand = 32'd0;
    $display("[TB] starting");
    test_reset();
    test_ring();
    test_window_zero();
    test_busy_ignore();
    test_saturation();
    test_ext_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
